// File: rtl/wb_spi_arbiter.sv
// Two-master round-robin pipelined Wishbone arbiter in front of the SPI controller slave.
// Tracks outstanding strobes per bus cycle and aborts the cycle with err_o on an ack timeout.
module wb_spi_arbiter #(
    parameter int unsigned AW      = 2,
    parameter int unsigned DW      = 32,
    parameter int unsigned TIMEOUT = 255,
    parameter int unsigned MAX_OUT = 3
) (
    input  logic            clk_i,
    input  logic            rst_ni,

    input  logic            m0_cyc_i,
    input  logic            m0_stb_i,
    input  logic            m0_we_i,
    input  logic [AW-1:0]   m0_addr_i,
    input  logic [DW-1:0]   m0_data_i,
    input  logic [DW/8-1:0] m0_sel_i,
    output logic            m0_stall_o,
    output logic            m0_ack_o,
    output logic            m0_err_o,
    output logic [DW-1:0]   m0_data_o,

    input  logic            m1_cyc_i,
    input  logic            m1_stb_i,
    input  logic            m1_we_i,
    input  logic [AW-1:0]   m1_addr_i,
    input  logic [DW-1:0]   m1_data_i,
    input  logic [DW/8-1:0] m1_sel_i,
    output logic            m1_stall_o,
    output logic            m1_ack_o,
    output logic            m1_err_o,
    output logic [DW-1:0]   m1_data_o,

    output logic            s_cyc_o,
    output logic            s_stb_o,
    output logic            s_we_o,
    output logic [AW-1:0]   s_addr_o,
    output logic [DW-1:0]   s_data_o,
    output logic [DW/8-1:0] s_sel_o,
    input  logic            s_stall_i,
    input  logic            s_ack_i,
    input  logic [DW-1:0]   s_data_i
);

    localparam int unsigned CW = (MAX_OUT < 1) ? 1 : $clog2(MAX_OUT + 1);
    localparam int unsigned TW = (TIMEOUT < 1) ? 1 : $clog2(TIMEOUT + 1);
    localparam logic [CW-1:0] MAX_CNT = CW'(MAX_OUT);
    localparam logic [TW-1:0] TO_CNT  = TW'(TIMEOUT);

    typedef enum logic {
        IDLE,
        BUSY
    } state_e;

    state_e          state_q, state_d;
    logic            owner_q, owner_d;
    logic            last_q, last_d;
    logic [CW-1:0]   count_q, count_d;
    logic [TW-1:0]   timer_q, timer_d;

    logic            busy;
    logic            own_cyc, own_stb, own_we;
    logic [AW-1:0]   own_addr;
    logic [DW-1:0]   own_data;
    logic [DW/8-1:0] own_sel;
    logic            full;
    logic            timeout_hit;
    logic            accept;
    logic            own0, own1;

    always_comb begin
        busy     = (state_q == BUSY);
        own_cyc  = owner_q ? m1_cyc_i  : m0_cyc_i;
        own_stb  = owner_q ? m1_stb_i  : m0_stb_i;
        own_we   = owner_q ? m1_we_i   : m0_we_i;
        own_addr = owner_q ? m1_addr_i : m0_addr_i;
        own_data = owner_q ? m1_data_i : m0_data_i;
        own_sel  = owner_q ? m1_sel_i  : m0_sel_i;
        full     = (count_q == MAX_CNT);
        // An ack in the expiry cycle wins, and a dropped cyc is a plain release.
        timeout_hit = (TIMEOUT != 0) && busy && own_cyc && !s_ack_i && (timer_q == TO_CNT);
        own0     = busy && !owner_q;
        own1     = busy && owner_q;
    end

    always_comb begin
        s_cyc_o  = busy && own_cyc && !timeout_hit;
        s_stb_o  = busy && own_cyc && own_stb && !full && !timeout_hit;
        s_we_o   = busy && own_we;
        s_addr_o = busy ? own_addr : '0;
        s_data_o = busy ? own_data : '0;
        s_sel_o  = busy ? own_sel  : '0;
        accept   = s_stb_o && !s_stall_i;

        m0_stall_o = own0 ? (s_stall_i || full) : 1'b1;
        m0_ack_o   = own0 && s_ack_i;
        m0_err_o   = own0 && timeout_hit;
        m0_data_o  = own0 ? s_data_i : '0;

        m1_stall_o = own1 ? (s_stall_i || full) : 1'b1;
        m1_ack_o   = own1 && s_ack_i;
        m1_err_o   = own1 && timeout_hit;
        m1_data_o  = own1 ? s_data_i : '0;
    end

    always_comb begin
        state_d = state_q;
        owner_d = owner_q;
        last_d  = last_q;
        count_d = count_q;
        timer_d = timer_q;
        case (state_q)
            IDLE: begin
                count_d = '0;
                timer_d = '0;
                if (m0_cyc_i || m1_cyc_i) begin
                    state_d = BUSY;
                    owner_d = (m0_cyc_i && m1_cyc_i) ? !last_q : m1_cyc_i;
                end
            end
            BUSY: begin
                if (!own_cyc || timeout_hit) begin
                    state_d = IDLE;
                    last_d  = owner_q;
                    count_d = '0;
                    timer_d = '0;
                end else begin
                    case ({accept, s_ack_i})
                        2'b10:   count_d = count_q + 1'b1;
                        2'b01:   count_d = (count_q != '0) ? count_q - 1'b1 : count_q;
                        default: count_d = count_q;
                    endcase
                    if ((TIMEOUT == 0) || s_ack_i || accept || (count_q == '0)) begin
                        timer_d = '0;
                    end else begin
                        timer_d = timer_q + 1'b1;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            state_q <= IDLE;
            owner_q <= 1'b0;
            last_q  <= 1'b1;
            count_q <= '0;
            timer_q <= '0;
        end else begin
            state_q <= state_d;
            owner_q <= owner_d;
            last_q  <= last_d;
            count_q <= count_d;
            timer_q <= timer_d;
        end
    end

endmodule

// File: tb/tb_wb_spi_arbiter.sv
// Directed bench for wb_spi_arbiter: per-cycle vector table plus hand-written timeout sequences.
module tb_wb_spi_arbiter;

    logic        clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_ni;
    logic        m0_cyc_i, m0_stb_i, m0_we_i;
    logic [1:0]  m0_addr_i;
    logic [31:0] m0_data_i;
    logic [3:0]  m0_sel_i;
    logic        m0_stall_o, m0_ack_o, m0_err_o;
    logic [31:0] m0_data_o;
    logic        m1_cyc_i, m1_stb_i, m1_we_i;
    logic [1:0]  m1_addr_i;
    logic [31:0] m1_data_i;
    logic [3:0]  m1_sel_i;
    logic        m1_stall_o, m1_ack_o, m1_err_o;
    logic [31:0] m1_data_o;
    logic        s_cyc_o, s_stb_o, s_we_o;
    logic [1:0]  s_addr_o;
    logic [31:0] s_data_o;
    logic [3:0]  s_sel_o;
    logic        s_stall_i, s_ack_i;
    logic [31:0] s_data_i;

    wb_spi_arbiter #(.AW(2), .DW(32), .TIMEOUT(8), .MAX_OUT(3)) dut (
        .clk_i(clk), .rst_ni(rst_ni),
        .m0_cyc_i(m0_cyc_i), .m0_stb_i(m0_stb_i), .m0_we_i(m0_we_i), .m0_addr_i(m0_addr_i),
        .m0_data_i(m0_data_i), .m0_sel_i(m0_sel_i), .m0_stall_o(m0_stall_o), .m0_ack_o(m0_ack_o),
        .m0_err_o(m0_err_o), .m0_data_o(m0_data_o),
        .m1_cyc_i(m1_cyc_i), .m1_stb_i(m1_stb_i), .m1_we_i(m1_we_i), .m1_addr_i(m1_addr_i),
        .m1_data_i(m1_data_i), .m1_sel_i(m1_sel_i), .m1_stall_o(m1_stall_o), .m1_ack_o(m1_ack_o),
        .m1_err_o(m1_err_o), .m1_data_o(m1_data_o),
        .s_cyc_o(s_cyc_o), .s_stb_o(s_stb_o), .s_we_o(s_we_o), .s_addr_o(s_addr_o),
        .s_data_o(s_data_o), .s_sel_o(s_sel_o), .s_stall_i(s_stall_i), .s_ack_i(s_ack_i),
        .s_data_i(s_data_i)
    );

    // fi = {rst_n, m0 cyc, m0 stb, m0 we, m1 cyc, m1 stb, s_stall, s_ack}
    // fe = {s_cyc, s_stb, s_we, m0 stall, m0 ack, m0 err, m1 stall, m1 ack, m1 err}
    typedef struct {
        string       name;
        logic [7:0]  fi;
        logic [1:0]  a0;
        logic [31:0] d0;
        logic [31:0] sd;
        logic [8:0]  fe;
        logic [1:0]  ea;
        logic [31:0] ed;
        logic [31:0] r0;
        logic [31:0] r1;
    } vec_t;

    vec_t vecs[$];
    int   checks = 0;
    int   errors = 0;

    function automatic void add(input string n, input logic [7:0] fi, input logic [1:0] a0,
                                input logic [31:0] d0, input logic [31:0] sd, input logic [8:0] fe,
                                input logic [1:0] ea, input logic [31:0] ed,
                                input logic [31:0] r0, input logic [31:0] r1);
        vec_t v;
        v.name = n; v.fi = fi; v.a0 = a0; v.d0 = d0; v.sd = sd;
        v.fe = fe; v.ea = ea; v.ed = ed; v.r0 = r0; v.r1 = r1;
        vecs.push_back(v);
    endfunction

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic drive(input vec_t v);
        {rst_ni, m0_cyc_i, m0_stb_i, m0_we_i, m1_cyc_i, m1_stb_i, s_stall_i, s_ack_i} = v.fi;
        m0_addr_i = v.a0;
        m0_data_i = v.d0;
        s_data_i  = v.sd;
    endtask

    function automatic logic [127:0] snap();
        return {21'b0, s_cyc_o, s_stb_o, s_we_o, m0_stall_o, m0_ack_o, m0_err_o,
                m1_stall_o, m1_ack_o, m1_err_o, s_addr_o, s_data_o, m0_data_o, m1_data_o};
    endfunction

    initial begin
        int n_err;
        int bad;

        rst_ni = 1'b0;
        m0_cyc_i = 1'b0; m0_stb_i = 1'b0; m0_we_i = 1'b0; m0_addr_i = '0; m0_data_i = '0;
        m0_sel_i = 4'hF;
        m1_cyc_i = 1'b0; m1_stb_i = 1'b0; m1_we_i = 1'b0; m1_addr_i = 2'd1; m1_data_i = '0;
        m1_sel_i = 4'hF;
        s_stall_i = 1'b0; s_ack_i = 1'b0; s_data_i = '0;

        // reset state, then single M0 write acked two cycles after acceptance
        add("rst",   8'b0_000_00_00, 2'd0, 32'h0, 32'h0, 9'b000_100_100, 2'd0, 32'h0, 32'h0, 32'h0);
        add("wr_req",8'b1_111_00_00, 2'd2, 32'hA5A5A5A5, 32'h0, 9'b000_100_100, 2'd0, 32'h0, 32'h0, 32'h0);
        add("wr_gnt",8'b1_111_00_00, 2'd2, 32'hA5A5A5A5, 32'h0, 9'b111_000_100, 2'd2, 32'hA5A5A5A5, 32'h0, 32'h0);
        add("wr_wt", 8'b1_101_00_00, 2'd2, 32'hA5A5A5A5, 32'h0, 9'b101_000_100, 2'd2, 32'hA5A5A5A5, 32'h0, 32'h0);
        add("wr_ack",8'b1_101_00_01, 2'd2, 32'hA5A5A5A5, 32'h0, 9'b101_010_100, 2'd2, 32'hA5A5A5A5, 32'h0, 32'h0);
        add("wr_rel",8'b1_000_00_00, 2'd0, 32'h0, 32'h0, 9'b000_000_100, 2'd0, 32'h0, 32'h0, 32'h0);
        add("wr_idl",8'b1_000_00_00, 2'd0, 32'h0, 32'h0, 9'b000_100_100, 2'd0, 32'h0, 32'h0, 32'h0);
        add("rst2",  8'b0_000_00_00, 2'd0, 32'h0, 32'h0, 9'b000_100_100, 2'd0, 32'h0, 32'h0, 32'h0);
        // tie twice: grant order M0, M1, M0, M1 with an IDLE cycle between owners
        for (int r = 0; r < 2; r++) begin
            add("tie_req", 8'b1_110_11_00, 2'd3, 32'h0, 32'h0, 9'b000_100_100, 2'd0, 32'h0, 32'h0, 32'h0);
            add("tie_m0",  8'b1_110_11_00, 2'd3, 32'h0, 32'h0, 9'b110_000_100, 2'd3, 32'h0, 32'h0, 32'h0);
            add("tie_a0",  8'b1_100_10_01, 2'd3, 32'h0, 32'hA0 + r, 9'b100_010_100, 2'd3, 32'h0, 32'hA0 + r, 32'h0);
            add("tie_r0",  8'b1_000_11_00, 2'd0, 32'h0, 32'h0, 9'b000_000_100, 2'd0, 32'h0, 32'h0, 32'h0);
            add("tie_gap", 8'b1_000_11_00, 2'd0, 32'h0, 32'h0, 9'b000_100_100, 2'd0, 32'h0, 32'h0, 32'h0);
            add("tie_m1",  8'b1_000_11_00, 2'd0, 32'h0, 32'h0, 9'b110_100_000, 2'd1, 32'h0, 32'h0, 32'h0);
            add("tie_a1",  8'b1_000_10_01, 2'd0, 32'h0, 32'hB0 + r, 9'b100_100_010, 2'd1, 32'h0, 32'h0, 32'hB0 + r);
            add("tie_r1",  8'b1_000_00_00, 2'd0, 32'h0, 32'h0, 9'b000_100_000, 2'd1, 32'h0, 32'h0, 32'h0);
        end
        // four back-to-back strobes against MAX_OUT=3
        add("pl_req", 8'b1_110_00_00, 2'd0, 32'h0, 32'h0, 9'b000_100_100, 2'd0, 32'h0, 32'h0, 32'h0);
        add("pl_s1",  8'b1_110_00_00, 2'd0, 32'h0, 32'h0, 9'b110_000_100, 2'd0, 32'h0, 32'h0, 32'h0);
        add("pl_s2",  8'b1_110_00_00, 2'd1, 32'h0, 32'h0, 9'b110_000_100, 2'd1, 32'h0, 32'h0, 32'h0);
        add("pl_s3",  8'b1_110_00_00, 2'd2, 32'h0, 32'h0, 9'b110_000_100, 2'd2, 32'h0, 32'h0, 32'h0);
        add("pl_full",8'b1_110_00_00, 2'd3, 32'h0, 32'h0, 9'b100_100_100, 2'd3, 32'h0, 32'h0, 32'h0);
        add("pl_a11", 8'b1_110_00_01, 2'd3, 32'h0, 32'h11, 9'b100_110_100, 2'd3, 32'h0, 32'h11, 32'h0);
        add("pl_a22", 8'b1_110_00_01, 2'd3, 32'h0, 32'h22, 9'b110_010_100, 2'd3, 32'h0, 32'h22, 32'h0);
        add("pl_a33", 8'b1_100_00_01, 2'd3, 32'h0, 32'h33, 9'b100_010_100, 2'd3, 32'h0, 32'h33, 32'h0);
        add("pl_a44", 8'b1_100_00_01, 2'd3, 32'h0, 32'h44, 9'b100_010_100, 2'd3, 32'h0, 32'h44, 32'h0);
        add("pl_rel", 8'b1_000_00_00, 2'd3, 32'h0, 32'h0, 9'b000_000_100, 2'd3, 32'h0, 32'h0, 32'h0);
        // reset with two strobes outstanding, late ack, then count must start from zero
        add("ro_req", 8'b1_110_00_00, 2'd1, 32'h0, 32'h0, 9'b000_100_100, 2'd0, 32'h0, 32'h0, 32'h0);
        add("ro_s1",  8'b1_110_00_00, 2'd1, 32'h0, 32'h0, 9'b110_000_100, 2'd1, 32'h0, 32'h0, 32'h0);
        add("ro_s2",  8'b1_110_00_00, 2'd2, 32'h0, 32'h0, 9'b110_000_100, 2'd2, 32'h0, 32'h0, 32'h0);
        add("ro_rst", 8'b0_100_00_00, 2'd2, 32'h0, 32'h0, 9'b100_000_100, 2'd2, 32'h0, 32'h0, 32'h0);
        add("ro_late",8'b1_000_00_01, 2'd0, 32'h0, 32'h55, 9'b000_100_100, 2'd0, 32'h0, 32'h0, 32'h0);
        add("ro_req2",8'b1_110_00_00, 2'd0, 32'h0, 32'h0, 9'b000_100_100, 2'd0, 32'h0, 32'h0, 32'h0);
        add("ro_t1",  8'b1_110_00_00, 2'd0, 32'h0, 32'h0, 9'b110_000_100, 2'd0, 32'h0, 32'h0, 32'h0);
        add("ro_t2",  8'b1_110_00_00, 2'd1, 32'h0, 32'h0, 9'b110_000_100, 2'd1, 32'h0, 32'h0, 32'h0);
        add("ro_a1",  8'b1_100_00_01, 2'd1, 32'h0, 32'h61, 9'b100_010_100, 2'd1, 32'h0, 32'h61, 32'h0);
        add("ro_a2",  8'b1_100_00_01, 2'd1, 32'h0, 32'h62, 9'b100_010_100, 2'd1, 32'h0, 32'h62, 32'h0);
        add("ro_rel", 8'b1_000_00_00, 2'd1, 32'h0, 32'h0, 9'b000_000_100, 2'd1, 32'h0, 32'h0, 32'h0);
        // release with one outstanding, ack arrives in IDLE, next grant is normal
        add("rl_req", 8'b1_110_00_00, 2'd0, 32'h0, 32'h0, 9'b000_100_100, 2'd0, 32'h0, 32'h0, 32'h0);
        add("rl_s1",  8'b1_110_00_00, 2'd0, 32'h0, 32'h0, 9'b110_000_100, 2'd0, 32'h0, 32'h0, 32'h0);
        add("rl_drop",8'b1_000_00_00, 2'd0, 32'h0, 32'h0, 9'b000_000_100, 2'd0, 32'h0, 32'h0, 32'h0);
        add("rl_late",8'b1_000_00_01, 2'd0, 32'h0, 32'h77, 9'b000_100_100, 2'd0, 32'h0, 32'h0, 32'h0);
        add("rl_req1",8'b1_000_11_00, 2'd0, 32'h0, 32'h0, 9'b000_100_100, 2'd0, 32'h0, 32'h0, 32'h0);
        add("rl_m1",  8'b1_000_11_00, 2'd0, 32'h0, 32'h0, 9'b110_100_000, 2'd1, 32'h0, 32'h0, 32'h0);
        add("rl_a1",  8'b1_000_10_01, 2'd0, 32'h0, 32'h88, 9'b100_100_010, 2'd1, 32'h0, 32'h0, 32'h88);
        add("rl_rel", 8'b1_000_00_00, 2'd0, 32'h0, 32'h0, 9'b000_100_000, 2'd1, 32'h0, 32'h0, 32'h0);
        add("rl_idle",8'b1_000_00_00, 2'd0, 32'h0, 32'h0, 9'b000_100_100, 2'd0, 32'h0, 32'h0, 32'h0);

        repeat (2) @(posedge clk);
        #1;
        foreach (vecs[i]) begin
            drive(vecs[i]);
            #4;
            chk(vecs[i].name, snap(),
                {21'b0, vecs[i].fe, vecs[i].ea, vecs[i].ed, vecs[i].r0, vecs[i].r1});
            @(posedge clk);
            #1;
        end

        // timeout: M0 read never acked, M1 waiting behind it
        m0_cyc_i = 1'b1; m0_stb_i = 1'b1; m0_we_i = 1'b0; m0_addr_i = 2'd2;
        @(posedge clk);
        #5;
        chk("to_accept", {s_cyc_o, s_stb_o, m0_stall_o}, 3'b110);
        @(posedge clk);
        #1;
        m0_stb_i = 1'b0;
        m1_cyc_i = 1'b1;
        n_err = 0;
        for (int n = 1; n <= 20; n++) begin
            #4;
            if (m0_err_o) begin
                n_err = n;
                chk("to_err_cycle", {s_cyc_o, s_stb_o, m1_err_o}, 3'b000);
                break;
            end
            @(posedge clk);
            #1;
        end
        chk("to_latency", n_err, 9);
        @(posedge clk);
        #1;
        m0_cyc_i = 1'b0;
        #4;
        chk("to_idle", {m0_err_o, s_cyc_o, m1_stall_o}, 3'b001);
        @(posedge clk);
        #1;
        m1_stb_i = 1'b1;
        #4;
        chk("to_m1_grant", {s_cyc_o, s_stb_o, m1_stall_o, m0_stall_o}, 4'b1101);

        // ack arriving in the expiry cycle wins over the timeout
        @(posedge clk);
        #1;
        m1_stb_i = 1'b0;
        bad = 0;
        for (int k = 1; k <= 8; k++) begin
            #4;
            if (m1_err_o || m1_ack_o || !s_cyc_o) bad++;
            @(posedge clk);
            #1;
        end
        chk("aw_quiet", bad, 0);
        s_ack_i = 1'b1;
        s_data_i = 32'h99;
        #4;
        chk("aw_ack", {m1_ack_o, m1_err_o, s_cyc_o, m1_data_o}, {3'b101, 32'h99});
        @(posedge clk);
        #1;
        s_ack_i = 1'b0;
        m1_cyc_i = 1'b0;
        #4;
        chk("aw_release", {m1_err_o, s_cyc_o, m1_stall_o}, 3'b000);
        @(posedge clk);
        #5;
        chk("aw_idle", {s_cyc_o, m1_stall_o, m0_stall_o}, 3'b011);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not complete, got timeout expected finish");
        $fatal(1);
    end

endmodule
